// File: rtl/kex_pingpong_buf.sv
`default_nettype none
// ============================================================================
// kex_pingpong_buf : two-bank ping-pong weight buffer, DMA fill vs PE read
// Revision : 1.0
// ============================================================================
module kex_pingpong_buf #(
  parameter  int DATA_W  = 12,
  parameter  int DEPTH   = 64,
  parameter  int OUT_REG = 0,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_done,
  output logic              fill_ready,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  input  logic              rd_release,
  output logic              data_avail,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        n_full,
  output logic              err
);

  logic [DATA_W-1:0] r_mem [0:1][0:DEPTH-1];

  logic              r_wb;
  logic              r_rb;
  logic [1:0]        r_v;
  logic              r_err;
  logic [DATA_W-1:0] r_s1_data;
  logic              r_s1_vld;

  logic              w_fill_ready;
  logic              w_data_avail;
  logic              w_wr_ok;
  logic              w_done_ok;
  logic              w_rd_ok;
  logic              w_rel_ok;
  logic              w_drop;
  logic [1:0]        w_v_nxt;

  assign w_fill_ready = ~r_v[r_wb];
  assign w_data_avail = r_v[r_rb];

  assign w_wr_ok   = wr_en      & w_fill_ready;
  assign w_done_ok = wr_done    & w_fill_ready;
  assign w_rd_ok   = rd_en      & w_data_avail;
  assign w_rel_ok  = rd_release & w_data_avail;

  assign w_drop = (wr_en      & ~w_fill_ready) |
                  (wr_done    & ~w_fill_ready) |
                  (rd_en      & ~w_data_avail) |
                  (rd_release & ~w_data_avail);

  // Done and release can never address the same bank, so set/clear don't collide.
  always_comb begin
    w_v_nxt = r_v;
    if (w_done_ok) w_v_nxt[r_wb] = 1'b1;
    if (w_rel_ok)  w_v_nxt[r_rb] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb  <= 1'b0;
      r_rb  <= 1'b0;
      r_v   <= 2'b00;
      r_err <= 1'b0;
    end else begin
      r_v   <= w_v_nxt;
      r_err <= w_drop;
      if (w_done_ok) r_wb <= ~r_wb;
      if (w_rel_ok)  r_rb <= ~r_rb;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wb][wr_addr] <= wr_data;
  end

  // Read bank/address are taken from the issue cycle, so a same-cycle release
  // still returns data from the pre-release bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_data <= '0;
      r_s1_vld  <= 1'b0;
    end else begin
      r_s1_vld <= w_rd_ok;
      if (w_rd_ok) r_s1_data <= r_mem[r_rb][rd_addr];
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] r_s2_data;
    logic              r_s2_vld;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s2_data <= '0;
        r_s2_vld  <= 1'b0;
      end else begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) r_s2_data <= r_s1_data;
      end
    end

    assign rd_data  = r_s2_data;
    assign rd_valid = r_s2_vld;
  end else begin : g_no_out_reg
    assign rd_data  = r_s1_data;
    assign rd_valid = r_s1_vld;
  end

  assign fill_ready = w_fill_ready;
  assign data_avail = w_data_avail;
  assign n_full     = {1'b0, r_v[0]} + {1'b0, r_v[1]};
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_kex_pingpong_buf.sv
`default_nettype none
// ============================================================================
// tb_kex_pingpong_buf : scoreboard bench driving OUT_REG=0 and OUT_REG=1 copies
// Revision : 1.0
// ============================================================================
module tb_kex_pingpong_buf;

  localparam int DW = 12;
  localparam int AW = 6;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, wr_done, rd_en, rd_release;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;

  logic          fr0, da0, rv0, er0, fr1, da1, rv1, er1;
  logic [DW-1:0] rd0, rd1;
  logic [1:0]    nf0, nf1;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   e0 = 0, e1 = 0, v0 = 0, v1 = 0;

  kex_pingpong_buf #(.DATA_W(DW), .DEPTH(64), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .fill_ready(fr0),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release),
    .data_avail(da0), .rd_data(rd0), .rd_valid(rv0), .n_full(nf0), .err(er0)
  );

  kex_pingpong_buf #(.DATA_W(DW), .DEPTH(64), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .fill_ready(fr1),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release),
    .data_avail(da1), .rd_data(rd1), .rd_valid(rv1), .n_full(nf1), .err(er1)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rd_valid must match the head of its queue, at the right cycle.
  always @(negedge clk) begin
    exp_t e;
    if (er0) e0++;
    if (er1) e1++;
    if (rv0) begin
      v0++;
      if (q0.size() == 0) chk("dut0 unexpected rd_valid", 1, 0);
      else begin
        e = q0.pop_front();
        chk("dut0 rd_data", int'(rd0), int'(e.data));
        chk("dut0 rd latency", cyc, e.due);
      end
    end
    if (rv1) begin
      v1++;
      if (q1.size() == 0) chk("dut1 unexpected rd_valid", 1, 0);
      else begin
        e = q1.pop_front();
        chk("dut1 rd_data", int'(rd1), int'(e.data));
        chk("dut1 rd latency", cyc, e.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic [DW-1:0] d, input bit both);
    exp_t e;
    e.data = d;
    e.due  = cyc + 1;
    q0.push_back(e);
    if (both) begin
      e.due = cyc + 2;
      q1.push_back(e);
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_done = 0; rd_en = 0; rd_release = 0;
  endtask

  task automatic status(input string name, input int fr, input int da, input int nf);
    chk({name, " fill_ready0"}, int'(fr0), fr);
    chk({name, " fill_ready1"}, int'(fr1), fr);
    chk({name, " data_avail0"}, int'(da0), da);
    chk({name, " data_avail1"}, int'(da1), da);
    chk({name, " n_full0"}, int'(nf0), nf);
    chk({name, " n_full1"}, int'(nf1), nf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int eb0, eb1, vb0, vb1;
    rst = 1; idle(); wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (3) step();
    rst = 0;
    step();
    status("reset", 1, 0, 0);
    chk("reset rd_valid0", int'(rv0), 0);
    chk("reset rd_valid1", int'(rv1), 0);
    chk("reset rd_data0", int'(rd0), 0);
    chk("reset rd_data1", int'(rd1), 0);
    chk("reset err0", int'(er0), 0);

    // Empty buffer: read and release are both dropped.
    eb0 = e0; eb1 = e1;
    rd_en = 1; rd_addr = 3; step();
    rd_en = 0; rd_release = 1; step();
    idle(); step(); step();
    chk("empty err0 pulses", e0 - eb0, 2);
    chk("empty err1 pulses", e1 - eb1, 2);
    status("empty", 1, 0, 0);

    // Fill bank 0 with i+100 and hand it over.
    for (int i = 0; i < 64; i++) begin
      wr_en = 1; wr_addr = AW'(i); wr_data = DW'(100 + i); step();
    end
    wr_en = 0; wr_done = 1; step();
    wr_done = 0;
    status("fill0", 1, 1, 1);
    rd_en = 1; rd_addr = 5; push_rd(12'd105, 1); step();
    rd_en = 0; step(); step();

    // Overlapped streaming read of bank 0 and fill of bank 1.
    eb0 = e0; eb1 = e1; vb0 = v0; vb1 = v1;
    for (int i = 0; i < 64; i++) begin
      wr_en = 1; wr_addr = AW'(i); wr_data = DW'(200 + i);
      rd_en = 1; rd_addr = AW'(i); push_rd(DW'(100 + i), 1);
      step();
    end
    idle(); wr_done = 1; step();
    wr_done = 0; step(); step();
    status("overlap", 0, 1, 2);
    chk("overlap valids0", v0 - vb0, 64);
    chk("overlap valids1", v1 - vb1, 64);
    chk("overlap err0", e0 - eb0, 0);
    chk("overlap err1", e1 - eb1, 0);

    // Both banks full: write and done are dropped.
    eb0 = e0; eb1 = e1;
    wr_en = 1; wr_addr = 0; wr_data = 12'hFFF; step();
    wr_en = 0; wr_done = 1; step();
    wr_done = 0; step(); step();
    chk("stall err0", e0 - eb0, 2);
    chk("stall err1", e1 - eb1, 2);
    status("stall", 0, 1, 2);
    rd_release = 1; step();
    rd_release = 0;
    status("release", 1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      rd_en = 1; rd_addr = AW'(i); push_rd(DW'(200 + i), 1); step();
    end
    idle(); step(); step();

    // All four events at once with one full bank.
    eb0 = e0; eb1 = e1;
    wr_en = 1; wr_addr = 63; wr_data = 12'hABC; wr_done = 1;
    rd_en = 1; rd_addr = 0; rd_release = 1; push_rd(12'd200, 1);
    step();
    idle();
    status("simul", 1, 1, 1);
    rd_en = 1; rd_addr = 63; push_rd(12'hABC, 1); step();
    rd_addr = 0; push_rd(12'd100, 1); step();
    idle(); step(); step();
    chk("simul err0", e0 - eb0, 0);
    chk("simul err1", e1 - eb1, 0);

    // Reset right behind an accepted read: only the latency-1 copy returns it.
    rd_en = 1; rd_addr = 10; push_rd(12'd110, 0); step();
    rd_en = 0; rst = 1; step();
    rst = 0;
    status("midrst", 1, 0, 0);
    chk("midrst rd_valid0", int'(rv0), 0);
    chk("midrst rd_valid1", int'(rv1), 0);
    chk("midrst rd_data0", int'(rd0), 0);
    chk("midrst rd_data1", int'(rd1), 0);
    step(); step(); step();
    chk("queue0 drained", q0.size(), 0);
    chk("queue1 drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
